// File: rtl/ysyx_23060208_wbu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060208_wbu_pkg
// Brief    : Execute-to-writeback bus layout and CSR constants.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_23060208_wbu_pkg;

    localparam int unsigned c_xlen              = 32;
    localparam int unsigned c_regw              = 5;
    localparam int unsigned c_exu_to_wbu_bus_w  = 225;

    localparam logic [11:0] c_csr_mepc          = 12'h341;
    localparam logic [11:0] c_csr_mcause        = 12'h342;
    localparam logic [31:0] c_mcause_ecall_m    = 32'h0000_000b;

    // Field order matches the execute stage packing, MSB first.
    typedef struct packed {
        logic [c_xlen-1:0]  pc;
        logic [31:0]        inst;
        logic               rf_wen;
        logic [c_regw-1:0]  rf_waddr;
        logic [c_xlen-1:0]  rf_wdata;
        logic               csr_wen;
        logic [11:0]        csr_waddr;
        logic [c_xlen-1:0]  csr_wdata;
        logic               csr_wen2;
        logic [11:0]        csr_waddr2;
        logic [c_xlen-1:0]  csr_wdata2;
        logic               redirect;
        logic [c_xlen-1:0]  nextpc;
    } exu_to_wbu_t;

    // x0 is hardwired to zero, so a write to it never reaches the regfile.
    function automatic logic rf_write_effective(input logic wen, input logic [c_regw-1:0] addr);
        return wen && (addr != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_23060208_wbu_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060208_wbu_if
// Brief    : Writeback stage bundle: execute handshake, commit ports, redirect.
// Revision : 1.0 - initial release
// ============================================================================
interface ysyx_23060208_wbu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_WIDTH  = 5
);
    import ysyx_23060208_wbu_pkg::*;

    logic [c_exu_to_wbu_bus_w-1:0] exu_to_wbu_bus;
    logic                          exu_to_wbu_valid;
    logic                          wbu_allowin;

    logic                          regfile_wen;
    logic [REG_WIDTH-1:0]          regfile_waddr;
    logic [DATA_WIDTH-1:0]         regfile_wdata;

    logic                          csr_wen;
    logic [11:0]                   csr_waddr;
    logic [DATA_WIDTH-1:0]         csr_wdata;
    logic                          csr_wen2;
    logic [11:0]                   csr_waddr2;
    logic [DATA_WIDTH-1:0]         csr_wdata2;

    logic                          wbu_to_ifu_valid;
    logic [DATA_WIDTH-1:0]         wbu_to_ifu_nextpc;
    logic                          ifu_redirect_ready;

    logic                          wbu_fwd_valid;
    logic [REG_WIDTH-1:0]          wbu_fwd_addr;
    logic [DATA_WIDTH-1:0]         wbu_fwd_data;

    logic                          wbu_commit;
    logic [63:0]                   wbu_instret;
    logic [DATA_WIDTH-1:0]         wbu_commit_pc;
    logic [31:0]                   wbu_commit_inst;

    // Environment side: execute stage, fetch stage, regfile/CSR file.
    modport master (
        output exu_to_wbu_bus, exu_to_wbu_valid, ifu_redirect_ready,
        input  wbu_allowin, regfile_wen, regfile_waddr, regfile_wdata,
        input  csr_wen, csr_waddr, csr_wdata, csr_wen2, csr_waddr2, csr_wdata2,
        input  wbu_to_ifu_valid, wbu_to_ifu_nextpc,
        input  wbu_fwd_valid, wbu_fwd_addr, wbu_fwd_data,
        input  wbu_commit, wbu_instret, wbu_commit_pc, wbu_commit_inst
    );

    // Writeback stage side.
    modport slave (
        input  exu_to_wbu_bus, exu_to_wbu_valid, ifu_redirect_ready,
        output wbu_allowin, regfile_wen, regfile_waddr, regfile_wdata,
        output csr_wen, csr_waddr, csr_wdata, csr_wen2, csr_waddr2, csr_wdata2,
        output wbu_to_ifu_valid, wbu_to_ifu_nextpc,
        output wbu_fwd_valid, wbu_fwd_addr, wbu_fwd_data,
        output wbu_commit, wbu_instret, wbu_commit_pc, wbu_commit_inst
    );

endinterface
`default_nettype wire

// File: rtl/ysyx_23060208_instret_cnt.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060208_instret_cnt
// Brief    : 64-bit retired-instruction counter, wraps to zero.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060208_instret_cnt (
    input  wire logic        clock,
    input  wire logic        reset,
    input  wire logic        i_en,
    output logic [63:0]      o_count
);

    logic [63:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ysyx_23060208_wbu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060208_wbu
// Brief    : Writeback stage: commits regfile/CSR writes and fetch redirect.
//            WBU_INSTRET_EN selects the 64-bit retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060208_wbu
    import ysyx_23060208_wbu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_WIDTH  = 5
) (
    input  wire logic              clock,
    input  wire logic              reset,
    ysyx_23060208_wbu_if.slave     bus_if
);

    exu_to_wbu_t            r_bus;
    exu_to_wbu_t            w_in;
    logic                   r_valid;
    logic                   w_ready_go;
    logic                   w_allowin;
    logic                   w_commit;
    logic                   w_rf_live;
    logic [REG_WIDTH-1:0]   w_rf_waddr;
    logic [DATA_WIDTH-1:0]  w_rf_wdata;

    assign w_in       = bus_if.exu_to_wbu_bus;
    assign w_rf_waddr = r_bus.rf_waddr;
    assign w_rf_wdata = r_bus.rf_wdata;

    // A redirecting instruction stays put until fetch takes the new pc.
    assign w_ready_go = !r_bus.redirect || bus_if.ifu_redirect_ready;
    assign w_allowin  = !r_valid || w_ready_go;
    assign w_commit   = r_valid && w_ready_go;
    assign w_rf_live  = rf_write_effective(r_bus.rf_wen, r_bus.rf_waddr);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_bus   <= '0;
        end else if (w_allowin) begin
            r_valid <= bus_if.exu_to_wbu_valid;
            if (bus_if.exu_to_wbu_valid) begin
                r_bus <= w_in;
            end
        end
    end

    assign bus_if.wbu_allowin       = w_allowin;
    assign bus_if.wbu_commit        = w_commit;
    assign bus_if.wbu_commit_pc     = r_bus.pc;
    assign bus_if.wbu_commit_inst   = r_bus.inst;

    assign bus_if.regfile_wen       = w_commit && w_rf_live;
    assign bus_if.regfile_waddr     = w_rf_waddr;
    assign bus_if.regfile_wdata     = w_rf_wdata;

    assign bus_if.csr_wen           = w_commit && r_bus.csr_wen;
    assign bus_if.csr_waddr         = r_bus.csr_waddr;
    assign bus_if.csr_wdata         = r_bus.csr_wdata;
    assign bus_if.csr_wen2          = w_commit && r_bus.csr_wen2;
    assign bus_if.csr_waddr2        = r_bus.csr_waddr2;
    assign bus_if.csr_wdata2        = r_bus.csr_wdata2;

    assign bus_if.wbu_to_ifu_valid  = r_valid && r_bus.redirect;
    assign bus_if.wbu_to_ifu_nextpc = r_bus.nextpc;

    // Forwarding ignores ready_go: the result is final even while stalled.
    assign bus_if.wbu_fwd_valid     = r_valid && w_rf_live;
    assign bus_if.wbu_fwd_addr      = w_rf_waddr;
    assign bus_if.wbu_fwd_data      = w_rf_wdata;

`ifdef WBU_INSTRET_EN
    ysyx_23060208_instret_cnt u_instret_cnt (
        .clock   (clock),
        .reset   (reset),
        .i_en    (w_commit),
        .o_count (bus_if.wbu_instret)
    );
`else
    assign bus_if.wbu_instret = '0;
`endif

endmodule
`default_nettype wire
